// File: rtl/blast_layer_seq.sv
// Chunked XNOR-popcount output layer with sequential argmax and a valid/ready result port.
// Scores are accumulated CHUNK_W bits per cycle for every neuron, then scanned one neuron per cycle.
module blast_layer_seq #(
   parameter  int ISIZE_FEAT = 64,
   parameter  int OSIZE_FEAT = 10,
   parameter  int CHUNK_W    = 16,
   parameter  int N_BITCONV  = 7,
   localparam int CLS_W      = $clog2(OSIZE_FEAT)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             clear_i,
   input  logic                             valid_i,
   output logic                             ready_o,
   input  logic [ISIZE_FEAT-1:0]            layer_i,
   input  logic [OSIZE_FEAT*ISIZE_FEAT-1:0] weights_i,
   output logic                             valid_o,
   input  logic                             ready_i,
   output logic [OSIZE_FEAT*N_BITCONV-1:0]  layer_o,
   output logic [CLS_W-1:0]                 class_o
);

   localparam int N_CHUNK = ISIZE_FEAT / CHUNK_W;
   localparam int ACC_W   = $clog2(ISIZE_FEAT + 1);
   localparam int CNT_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
   localparam int SAT_MAX = (1 << N_BITCONV) - 1;

   typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;

   state_t                  state, state_nxt;
   logic [ISIZE_FEAT-1:0]   in_q;
   logic [ACC_W-1:0]        acc       [OSIZE_FEAT];
   logic [ACC_W-1:0]        chunk_sum [OSIZE_FEAT];
   logic [CNT_W-1:0]        chunk_cnt;
   logic [CLS_W-1:0]        nidx;
   logic [ACC_W-1:0]        best_val;
   logic [CLS_W-1:0]        best_idx;

   logic accept, do_accum, do_argmax, last_chunk, last_neuron, leave_done, best_upd;

   function automatic logic [ACC_W-1:0] popcnt(input logic [CHUNK_W-1:0] v);
      logic [ACC_W-1:0] n;
      n = '0;
      for (int i = 0; i < CHUNK_W; i++) n = n + ACC_W'(v[i]);
      return n;
   endfunction

   function automatic logic [N_BITCONV-1:0] sat(input logic [ACC_W-1:0] a);
      if (int'(a) > SAT_MAX) return '1;
      return N_BITCONV'(a);
   endfunction

   // XNOR-popcount of the current chunk for every neuron in parallel.
   always_comb begin
      for (int k = 0; k < OSIZE_FEAT; k++)
         chunk_sum[k] = popcnt(~(in_q[chunk_cnt*CHUNK_W +: CHUNK_W] ^
                                 weights_i[k*ISIZE_FEAT + chunk_cnt*CHUNK_W +: CHUNK_W]));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      do_accum    = 1'b0;
      do_argmax   = 1'b0;
      leave_done  = 1'b0;
      last_chunk  = (chunk_cnt == CNT_W'(N_CHUNK - 1));
      last_neuron = (nidx == CLS_W'(OSIZE_FEAT - 1));
      best_upd    = (acc[nidx] > best_val);
      unique case (state)
         IDLE: if (valid_i) begin
            accept    = 1'b1;
            state_nxt = ACCUM;
         end
         ACCUM: begin
            do_accum = 1'b1;
            if (last_chunk) state_nxt = ARGMAX;
         end
         ARGMAX: begin
            do_argmax = 1'b1;
            if (last_neuron) state_nxt = DONE;
         end
         DONE: if (ready_i) begin
            leave_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (clear_i) begin
         state_nxt  = IDLE;
         accept     = 1'b0;
         do_accum   = 1'b0;
         do_argmax  = 1'b0;
         leave_done = 1'b0;
      end
   end

   assign ready_o = (state == IDLE);

   // NOTE: the accumulator array is small register storage and must read zero after reset, so it is reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         in_q      <= '0;
         chunk_cnt <= '0;
         nidx      <= '0;
         best_val  <= '0;
         best_idx  <= '0;
         valid_o   <= 1'b0;
         layer_o   <= '0;
         class_o   <= '0;
         for (int k = 0; k < OSIZE_FEAT; k++) acc[k] <= '0;
      end else if (clear_i) begin
         chunk_cnt <= '0;
         nidx      <= '0;
         best_val  <= '0;
         best_idx  <= '0;
         valid_o   <= 1'b0;
         layer_o   <= '0;
         class_o   <= '0;
         for (int k = 0; k < OSIZE_FEAT; k++) acc[k] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         if (accept) begin
            in_q      <= layer_i;
            chunk_cnt <= '0;
            for (int k = 0; k < OSIZE_FEAT; k++) acc[k] <= '0;
         end
         if (do_accum) begin
            for (int k = 0; k < OSIZE_FEAT; k++) acc[k] <= acc[k] + chunk_sum[k];
            chunk_cnt <= last_chunk ? '0 : chunk_cnt + 1'b1;
            if (last_chunk) begin
               nidx     <= '0;
               best_val <= '0;
               best_idx <= '0;
            end
         end
         if (do_argmax) begin
            if (best_upd) begin
               best_val <= acc[nidx];
               best_idx <= nidx;
            end
            nidx <= last_neuron ? '0 : nidx + 1'b1;
            // Publish on the last scan step, folding in that step's compare result.
            if (last_neuron) begin
               valid_o <= 1'b1;
               class_o <= best_upd ? nidx : best_idx;
               for (int k = 0; k < OSIZE_FEAT; k++)
                  layer_o[k*N_BITCONV +: N_BITCONV] <= sat(acc[k]);
            end
         end
         if (leave_done) begin
            valid_o <= 1'b0;
            layer_o <= '0;
            class_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_blast_layer_seq.sv
// Randomised and directed bench for blast_layer_seq; two instances (N_BITCONV 7 and 6) share stimulus.
// Expected scores come from a bit-equality count over the whole vector, independent of chunking.
module tb_blast_layer_seq;

   localparam int ISZ = 64;
   localparam int OSZ = 10;
   localparam int LAT = 4 + OSZ;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             clear_i = 1'b0;
   logic             valid_i = 1'b0;
   logic             ready_i = 1'b0;
   logic [ISZ-1:0]   layer_i = '0;
   logic [OSZ*ISZ-1:0] weights_i = '0;
   logic             ready_o, valid_o, ready6, valid6;
   logic [OSZ*7-1:0] layer_o;
   logic [OSZ*6-1:0] layer6;
   logic [3:0]       class_o, class6;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   blast_layer_seq #(.ISIZE_FEAT(ISZ), .OSIZE_FEAT(OSZ), .CHUNK_W(16), .N_BITCONV(7)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i), .ready_o(ready_o),
      .layer_i(layer_i), .weights_i(weights_i), .valid_o(valid_o), .ready_i(ready_i),
      .layer_o(layer_o), .class_o(class_o));

   blast_layer_seq #(.ISIZE_FEAT(ISZ), .OSIZE_FEAT(OSZ), .CHUNK_W(16), .N_BITCONV(6)) dut6 (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i), .ready_o(ready6),
      .layer_i(layer_i), .weights_i(weights_i), .valid_o(valid6), .ready_i(ready_i),
      .layer_o(layer6), .class_o(class6));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int score(input logic [ISZ-1:0] l, input logic [OSZ*ISZ-1:0] w, input int k);
      int s = 0;
      for (int i = 0; i < ISZ; i++) if (l[i] == w[k*ISZ + i]) s++;
      return s;
   endfunction

   function automatic int satv(input int s, input int nb);
      return (s > (1 << nb) - 1) ? (1 << nb) - 1 : s;
   endfunction

   // One full transaction: accept, latency, scores, class, optional back-pressure, handshake.
   task automatic run_vec(input string tag, input logic [ISZ-1:0] l, input logic [OSZ*ISZ-1:0] w,
                          input int hold, input bit pulse_valid);
      int sc [OSZ];
      int best, lat, n;
      logic [OSZ*7-1:0] e7;
      logic [OSZ*6-1:0] e6;
      best = 0;
      for (int k = 0; k < OSZ; k++) begin
         sc[k] = score(l, w, k);
         if (sc[k] > sc[best]) best = k;
         e7[k*7 +: 7] = 7'(satv(sc[k], 7));
         e6[k*6 +: 6] = 6'(satv(sc[k], 6));
      end
      layer_i = l; weights_i = w; valid_i = 1'b1;
      n = 0;
      while (!ready_o && n < 50) begin tick(); n++; end
      check({tag, " ready_before_accept"}, ready_o, 1'b1);
      tick();
      valid_i = 1'b0;
      layer_i = {$urandom, $urandom};
      lat = 0;
      while (!valid_o && lat < 100) begin tick(); lat++; end
      check({tag, " latency"}, lat, LAT);
      for (int k = 0; k < OSZ; k++) begin
         check($sformatf("%s score7[%0d]", tag, k), layer_o[k*7 +: 7], e7[k*7 +: 7]);
         check($sformatf("%s score6[%0d]", tag, k), layer6[k*6 +: 6], e6[k*6 +: 6]);
      end
      check({tag, " class7"}, class_o, best);
      check({tag, " class6"}, class6, best);
      for (int j = 0; j < hold; j++) begin
         if (pulse_valid && j == 1) valid_i = 1'b1;
         tick();
         valid_i = 1'b0;
         check({tag, " hold valid"}, valid_o, 1'b1);
         check({tag, " hold ready"}, ready_o, 1'b0);
         check({tag, " hold layer"}, layer_o, e7);
         check({tag, " hold class"}, class_o, best);
      end
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      check({tag, " valid_drop"}, valid_o, 1'b0);
      check({tag, " ready_back"}, ready_o, 1'b1);
   endtask

   function automatic logic [OSZ*ISZ-1:0] one_rows(input int a, input int b);
      logic [OSZ*ISZ-1:0] w = '0;
      for (int k = 0; k < OSZ; k++) if (k == a || k == b) w[k*ISZ +: ISZ] = '1;
      return w;
   endfunction

   initial begin
      logic [OSZ*ISZ-1:0] w;
      logic [ISZ-1:0]     l;
      int n;

      #3;
      check("reset ready", ready_o, 1'b1);
      check("reset valid", valid_o, 1'b0);
      check("reset layer", layer_o, '0);
      check("reset class", class_o, '0);
      #20 rst_ni = 1'b1;
      tick();

      run_vec("s1", '1, one_rows(3, 3), 0, 1'b0);
      run_vec("s2 tie", '1, one_rows(2, 7), 0, 1'b0);
      w = one_rows(4, 1);
      w[1*ISZ] = 1'b0;
      run_vec("s3 sat", '1, w, 0, 1'b0);
      run_vec("s4 backpressure", '1, one_rows(3, 3), 5, 1'b1);

      // Abort in the second ACCUM cycle.
      layer_i = '1; weights_i = one_rows(3, 3); valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      tick();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("s5 clear ready", ready_o, 1'b1);
      n = 0;
      for (int j = 0; j < 20; j++) begin tick(); if (valid_o) n++; end
      check("s5 no valid", n, 0);
      // clear_i wins over valid_i in IDLE.
      valid_i = 1'b1; clear_i = 1'b1;
      tick();
      valid_i = 1'b0; clear_i = 1'b0;
      check("clear+valid not accepted", ready_o, 1'b1);
      run_vec("s5 after", '1, one_rows(3, 3), 0, 1'b0);

      // Asynchronous reset in the middle of the argmax scan.
      layer_i = '1; weights_i = one_rows(3, 3); valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      for (int j = 0; j < 7; j++) tick();
      check("s6 busy before reset", ready_o, 1'b0);
      #2 rst_ni = 1'b0;
      #1;
      check("s6 async ready", ready_o, 1'b1);
      check("s6 async valid", valid_o, 1'b0);
      check("s6 async layer", layer_o, '0);
      check("s6 async class", class_o, '0);
      #10 rst_ni = 1'b1;
      tick();
      run_vec("s6 after", '1, one_rows(3, 3), 0, 1'b0);

      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < OSZ*ISZ/32; i++) w[i*32 +: 32] = $urandom;
         l = {$urandom, $urandom};
         // Sometimes bias rows toward the input or duplicate a row to exercise saturation and ties.
         if ($urandom_range(0, 2) == 0) w[$urandom_range(0, OSZ-1)*ISZ +: ISZ] = l;
         if ($urandom_range(0, 2) == 0) begin
            n = $urandom_range(0, OSZ-2);
            w[(n+1)*ISZ +: ISZ] = w[n*ISZ +: ISZ];
         end
         run_vec($sformatf("rnd%0d", t), l, w, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
